// File: rtl/muldiv_seq.sv
// Sequential 32-bit mulw/divw/remw unit for the EX stage: shift-add multiply, restoring divide.
// Optional MULDIV_FASTPATH_EN: divide-by-zero and divw overflow skip the iterative sequence.
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [3:0] OP_MULW = 4'b1001;
    localparam logic [3:0] OP_DIVW = 4'b1101;
    localparam logic [3:0] OP_REMW = 4'b1110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [XLEN-1:0] result_q;

    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] hi_q, lo_q, mcand_q;
    logic        neg_q, a_neg_q, div_zero_q, ovf_q;

    logic [31:0] in_a, in_b, abs_a, abs_b;
    logic        is_muldiv, in_mul, in_zero, in_ovf, accept, fast_path;
    logic        unused_upper;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] special_value(input logic [3:0] op,
                                                      input logic [31:0] a,
                                                      input logic zero);
        logic [31:0] r;
        if (zero) r = (op == OP_DIVW) ? 32'hFFFF_FFFF : a;
        else      r = (op == OP_DIVW) ? 32'h8000_0000 : 32'h0000_0000;
        return sext(r);
    endfunction

    assign in_a         = op_a[31:0];
    assign in_b         = op_b[31:0];
    assign unused_upper = ^{op_a[XLEN-1:32], op_b[XLEN-1:32]};
    assign abs_a        = in_a[31] ? -in_a : in_a;
    assign abs_b        = in_b[31] ? -in_b : in_b;
    assign in_mul       = (alu_control == OP_MULW);
    assign is_muldiv    = in_mul || (alu_control == OP_DIVW) || (alu_control == OP_REMW);
    assign in_zero      = (in_b == 32'h0);
    assign in_ovf       = (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);
    assign accept       = rst_n && !flush && (state_q == IDLE) && start && is_muldiv;

`ifdef MULDIV_FASTPATH_EN
    assign fast_path = !in_mul && (in_zero || in_ovf);
`else
    assign fast_path = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = fast_path ? DONE : CALC;
                CALC: if (cnt_q == 5'd31) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE) && !flush;
        stall = rst_n && (accept || (state_q == CALC) || (state_q == FIX));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                  cnt_q <= 5'd0;
        else if (accept)             cnt_q <= 5'd0;
        else if (state_q == CALC)    cnt_q <= cnt_q + 5'd1;
    end

    // One iteration: mul shifts {hi,lo} right after a conditional add; div shifts the
    // partial remainder left and keeps the trial subtraction when it does not underflow.
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [31:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
        div_shift = {hi_q, lo_q[31]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (op_q == OP_MULW) begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], lo_q[31:1]};
        end else if (!div_diff[32]) begin
            step_hi = div_diff[31:0];
            step_lo = {lo_q[30:0], 1'b1};
        end else begin
            step_hi = div_shift[31:0];
            step_lo = {lo_q[30:0], 1'b0};
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on acceptance before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q       <= alu_control;
            a_q        <= in_a;
            neg_q      <= in_a[31] ^ in_b[31];
            a_neg_q    <= in_a[31];
            div_zero_q <= in_zero;
            ovf_q      <= in_ovf;
            hi_q       <= 32'h0;
            lo_q       <= in_mul ? abs_b : abs_a;
            mcand_q    <= in_mul ? abs_a : abs_b;
        end else if (state_q == CALC) begin
            hi_q <= step_hi;
            lo_q <= step_lo;
        end
    end

    logic [XLEN-1:0] fix_value;

    always_comb begin
        if (op_q == OP_MULW)
            fix_value = sext(neg_q ? -lo_q : lo_q);
        else if (div_zero_q || ovf_q)
            fix_value = special_value(op_q, a_q, div_zero_q);
        else if (op_q == OP_DIVW)
            fix_value = sext(neg_q ? -lo_q : lo_q);
        else
            fix_value = sext(a_neg_q ? -hi_q : hi_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            result_q <= '0;
        else if (accept && fast_path)
            result_q <= special_value(alu_control, in_a, in_zero);
        else if (state_q == FIX && !flush)
            result_q <= fix_value;
    end

    assign result = result_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width. Only 64 is supported.
REQ-002 SHALL have port clk, input, 1: the single clock. All state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1: request from the EX stage, qualified by alu_control.
REQ-005 SHALL have port alu_control, input, 4: ALU opcode. 4'b1001 mulw, 4'b1101 divw, 4'b1110 remw. All other codes are not muldiv.
REQ-006 SHALL have port op_a, input, XLEN: rs1 value. Only bits [31:0] are used.
REQ-007 SHALL have port op_b, input, XLEN: rs2 value. Only bits [31:0] are used.
REQ-008 SHALL have port flush, input, 1: pipeline flush. Aborts the operation in progress.
REQ-009 SHALL have port stall, output, 1: freezes IF/ID/EX while high.
REQ-010 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when the result is valid.
REQ-012 SHALL have port result, output, XLEN: sign-extended 32-bit result.

Function
REQ-013 SHALL accept a request only in IDLE, when start=1 and alu_control is one of the three muldiv codes. On acceptance it latches the opcode and op_a[31:0]/op_b[31:0].
REQ-014 SHALL ignore start while not in IDLE, and SHALL ignore non-muldiv codes in every state.
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE:
- IDLE->CALC on acceptance.
- CALC->FIX when the 5-bit iteration counter reaches 31, i.e. after exactly 32 CALC cycles.
- FIX->DONE.
- DONE->IDLE unconditionally.
REQ-016 SHALL implement mulw as a 32-iteration shift-add on the magnitude of the operands. The result is bits [31:0] of the product, sign-extended to 64.
REQ-017 SHALL implement divw/remw as a 32-iteration restoring divide of the absolute values. In FIX it applies sign correction:
- quotient negated if the operand signs differ;
- remainder takes the sign of the dividend.
REQ-018 SHALL force special-case results in FIX:
- divisor 0: divw = 64'hFFFF_FFFF_FFFF_FFFF; remw = sext(op_a[31:0]).
- op_a[31:0]=32'h8000_0000 with op_b[31:0]=32'hFFFF_FFFF: divw = 64'hFFFF_FFFF_8000_0000; remw = 0.
REQ-019 SHALL drive stall combinationally high in the acceptance cycle, and registered-high in CALC and FIX. Stall is low in DONE and IDLE.
REQ-020 SHALL assert done for exactly the DONE cycle, with result valid in that same cycle. Latency is start cycle + 34 (32 CALC, 1 FIX, 1 DONE).
REQ-021 SHALL hold result stable from DONE until the next acceptance.
REQ-022 SHALL give flush priority over all other events:
- flush=1 in any state moves the FSM to IDLE on the next edge.
- flush suppresses done and a same-cycle acceptance.
- result is left unchanged.

Reset
REQ-023 SHALL, with rst_n=0 at a rising edge, set state=IDLE, counter=0, result=0, busy=0, done=0. This applies including mid-operation.
REQ-024 SHALL hold stall=0 while rst_n=0, regardless of start.

Configuration
REQ-025 SHALL support the macro MULDIV_FASTPATH_EN:
- Defined: divide-by-zero and divw overflow cases go IDLE->DONE directly. done is high in the cycle after acceptance (latency 1), and stall is high only in the acceptance cycle.
- Undefined: these cases run the full 34-cycle sequence. The results are identical in both builds.

Verification
REQ-026 SHALL cover: mulw with op_a=7, op_b=-3 -> done at cycle 34, result=64'hFFFF_FFFF_FFFF_FFEB.
REQ-027 SHALL cover: divw op_a=-20, op_b=6 -> result=64'hFFFF_FFFF_FFFF_FFFD. remw of the same operands -> 64'hFFFF_FFFF_FFFF_FFFE.
REQ-028 SHALL cover: divw op_b=0 -> result all-ones. Latency is 1 with MULDIV_FASTPATH_EN, 34 without.
REQ-029 SHALL cover: divw 0x8000_0000 / 0xFFFF_FFFF -> 64'hFFFF_FFFF_8000_0000. remw of the same operands -> 0.
REQ-030 SHALL cover: flush at CALC cycle 10 -> IDLE next cycle, no done pulse, stall low. A new start is then accepted normally.
REQ-031 SHALL cover: rst_n=0 at CALC cycle 20 -> busy=0, done=0, result=0 on the next edge. start with alu_control=4'b0010 -> no busy and no stall.
